// File: rtl/slice_alu_pkg.sv
// Shared opcodes, FSM state type and sel decode helper for the slice-serial ALU.
package slice_alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_AND = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b01000;
    localparam logic [4:0] OP_XOR = 5'b10000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_onehot(input logic [4:0] s);
        return (s != 5'd0) && ((s & (s - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/slice_alu_cell.sv
// Combinational SLICE-bit ALU cell; sub is a + ~b + c_in, illegal op yields all zeros.
module slice_alu_cell
    import slice_alu_pkg::*;
#(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic [4:0]       op,
    input  logic             c_in,
    output logic [SLICE-1:0] z_s,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [SLICE-1:0] bx;
    logic [SLICE-1:0] sum;
    logic             cy;
    logic             cy_msb;

    // Ripple across the slice with a scalar carry to avoid a self-referencing vector.
    always_comb begin
        bx     = (op == OP_SUB) ? ~b_s : b_s;
        sum    = '0;
        cy     = c_in;
        cy_msb = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) cy_msb = cy;
            sum[i] = a_s[i] ^ bx[i] ^ cy;
            cy     = (a_s[i] & bx[i]) | (a_s[i] & cy) | (bx[i] & cy);
        end
    end

    always_comb begin
        z_s      = '0;
        c_out    = 1'b0;
        c_msb_in = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                z_s      = sum;
                c_out    = cy;
                c_msb_in = cy_msb;
            end
            OP_AND:  z_s = a_s & b_s;
            OP_OR:   z_s = a_s | b_s;
            OP_XOR:  z_s = a_s ^ b_s;
            default: z_s = '0;
        endcase
    end

endmodule

// File: rtl/slice_serial_alu.sv
// Slice-serial ALU: one SLICE-bit cell reused over WIDTH/SLICE cycles, LSB slice first.
// Optional zero flag port enabled by defining SLICE_SERIAL_ALU_ZFLAG_EN.
module slice_serial_alu
    import slice_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       sel,
    input  logic             cin,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             overflow,
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
    output logic             zero,
`endif
    output logic             err
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_param
            $error("slice_serial_alu: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, z_q;
    logic [4:0]       sel_q;
    logic             c_q, carry_q, ovf_q, err_q, vld_q;
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
    logic             zacc_q, zero_q;
`endif

    logic [SLICE-1:0] z_s;
    logic             c_out, c_msb_in;
    logic             last_slice;

    slice_alu_cell #(.SLICE(SLICE)) u_cell (
        .a_s      (a_q[SLICE-1:0]),
        .b_s      (b_q[SLICE-1:0]),
        .op       (sel_q),
        .c_in     (c_q),
        .z_s      (z_s),
        .c_out    (c_out),
        .c_msb_in (c_msb_in)
    );

    assign last_slice = (cnt_q == CW'(NSLICE - 1));
    assign in_ready   = (state_q == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            sel_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
            zacc_q  <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        sel_q   <= sel;
                        cnt_q   <= '0;
                        z_q     <= '0;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        err_q   <= !is_onehot(sel);
                        c_q     <= (sel == OP_ADD) ? cin : ((sel == OP_SUB) ? ~bin : 1'b0);
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
                        zacc_q  <= 1'b1;
                        zero_q  <= 1'b0;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    z_q[int'(cnt_q) * SLICE +: SLICE] <= z_s;
                    a_q <= a_q >> SLICE;
                    b_q <= b_q >> SLICE;
                    c_q <= c_out;
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
                    zacc_q <= zacc_q & ~|z_s;
`endif
                    if (last_slice) begin
                        // Sub carries out of a + ~b; borrow is its complement.
                        carry_q <= (sel_q == OP_ADD) ? c_out : ((sel_q == OP_SUB) ? ~c_out : 1'b0);
                        ovf_q   <= ((sel_q == OP_ADD) || (sel_q == OP_SUB)) & (c_msb_in ^ c_out);
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
                        zero_q  <= zacc_q & ~|z_s;
`endif
                        vld_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        vld_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = vld_q;
    assign z         = z_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign err       = err_q;
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_slice_serial_alu.sv
// Directed bench for slice_serial_alu (8/2) plus a 16-bit sweep over SLICE=1/4/16.
module tb_slice_serial_alu;
    import slice_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, z;
    logic [4:0] sel;
    logic       cin, bin, carry, overflow, err;
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
    logic       zero;
    logic [2:0] wzero;
`endif

    logic             wvalid, wready_o;
    logic [2:0]       wrdy, wval, wc, wov, werr;
    logic [2:0][15:0] wz;
    logic [15:0]      wa, wb;
    logic [4:0]       wsel;
    logic             wcin, wbin;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    slice_serial_alu #(.WIDTH(8), .SLICE(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .cin(cin), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .carry(carry), .overflow(overflow),
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
        .zero(zero),
`endif
        .err(err)
    );

    slice_serial_alu #(.WIDTH(16), .SLICE(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(wvalid), .in_ready(wrdy[0]),
        .a(wa), .b(wb), .sel(wsel), .cin(wcin), .bin(wbin),
        .out_valid(wval[0]), .out_ready(wready_o),
        .z(wz[0]), .carry(wc[0]), .overflow(wov[0]),
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
        .zero(wzero[0]),
`endif
        .err(werr[0])
    );

    slice_serial_alu #(.WIDTH(16), .SLICE(4)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(wvalid), .in_ready(wrdy[1]),
        .a(wa), .b(wb), .sel(wsel), .cin(wcin), .bin(wbin),
        .out_valid(wval[1]), .out_ready(wready_o),
        .z(wz[1]), .carry(wc[1]), .overflow(wov[1]),
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
        .zero(wzero[1]),
`endif
        .err(werr[1])
    );

    slice_serial_alu #(.WIDTH(16), .SLICE(16)) u_s16 (
        .clk(clk), .rst(rst), .in_valid(wvalid), .in_ready(wrdy[2]),
        .a(wa), .b(wb), .sel(wsel), .cin(wcin), .bin(wbin),
        .out_valid(wval[2]), .out_ready(wready_o),
        .z(wz[2]), .carry(wc[2]), .overflow(wov[2]),
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
        .zero(wzero[2]),
`endif
        .err(werr[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [7:0] ez, input logic ec,
                           input logic eo, input logic ee);
        chk({tag, ".z"}, 32'(z), 32'(ez));
        chk({tag, ".carry"}, 32'(carry), 32'(ec));
        chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
        chk({tag, ".err"}, 32'(err), 32'(ee));
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
        chk({tag, ".zero"}, 32'(zero), 32'(ez == 8'h00));
`endif
    endtask

    // Present one op from just after an edge; returns edges from accept to out_valid.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [4:0] ts,
                          input logic tci, input logic tbi, output int lat);
        a = ta; b = tb; sel = ts; cin = tci; bin = tbi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'hA5; b = 8'h5A; sel = OP_XOR; cin = 1'b1; bin = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic void ref16(input logic [15:0] ra, input logic [15:0] rb, input logic [4:0] rs,
                                  input logic rci, input logic rbi,
                                  output logic [15:0] ez, output logic ec, output logic eo,
                                  output logic ee);
        logic [16:0] s;
        ez = 16'h0; ec = 1'b0; eo = 1'b0; ee = 1'b0;
        case (rs)
            OP_ADD: begin
                s  = {1'b0, ra} + {1'b0, rb} + {16'h0, rci};
                ez = s[15:0]; ec = s[16];
                eo = (ra[15] == rb[15]) && (ez[15] != ra[15]);
            end
            OP_SUB: begin
                s  = {1'b0, ra} - {1'b0, rb} - {16'h0, rbi};
                ez = s[15:0]; ec = s[16];
                eo = (ra[15] != rb[15]) && (ez[15] != ra[15]);
            end
            OP_AND:  ez = ra & rb;
            OP_OR:   ez = ra | rb;
            OP_XOR:  ez = ra ^ rb;
            default: ee = 1'b1;
        endcase
    endfunction

    initial begin
        int lat;
        logic [4:0] ops [0:6];
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR;
        ops[4] = OP_XOR; ops[5] = 5'b00000; ops[6] = 5'b10100;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sel = OP_ADD; cin = 1'b0; bin = 1'b0;
        wvalid = 1'b0; wready_o = 1'b1; wa = '0; wb = '0; wsel = OP_ADD; wcin = 1'b0; wbin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk_res("rst", 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef SLICE_SERIAL_ALU_ZFLAG_EN
        chk("rst.zero_low", 32'(zero), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("idle.in_ready", 32'(in_ready), 32'd1);

        // add with latency check
        run_op(8'h02, 8'h8B, OP_ADD, 1'b0, 1'b0, lat);
        chk("add.lat", 32'(lat), 32'd4);
        chk_res("add", 8'h8D, 1'b0, 1'b0, 1'b0);
        consume();
        chk("add.rel_valid", 32'(out_valid), 32'd0);
        chk("add.rel_ready", 32'(in_ready), 32'd1);

        run_op(8'h82, 8'h0B, OP_SUB, 1'b0, 1'b1, lat);
        chk_res("sub1", 8'h76, 1'b0, 1'b1, 1'b0);
        consume();
        run_op(8'h00, 8'h01, OP_SUB, 1'b0, 1'b0, lat);
        chk_res("sub2", 8'hFF, 1'b1, 1'b0, 1'b0);
        consume();

        run_op(8'h02, 8'h0B, OP_AND, 1'b1, 1'b1, lat);
        chk_res("and", 8'h02, 1'b0, 1'b0, 1'b0);
        consume();
        run_op(8'h82, 8'h8B, OP_OR, 1'b1, 1'b1, lat);
        chk_res("or", 8'h8B, 1'b0, 1'b0, 1'b0);
        consume();
        run_op(8'h82, 8'h8B, OP_XOR, 1'b1, 1'b1, lat);
        chk_res("xor", 8'h09, 1'b0, 1'b0, 1'b0);
        consume();
        run_op(8'hFF, 8'h01, OP_ADD, 1'b0, 1'b0, lat);
        chk_res("addwrap", 8'h00, 1'b1, 1'b0, 1'b0);
        consume();

        // backpressure: result must hold and a new request must be ignored
        run_op(8'h7F, 8'h01, OP_ADD, 1'b0, 1'b0, lat);
        for (int i = 0; i < 3; i++) begin
            a = 8'h33; b = 8'h44; sel = OP_OR; in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp.valid", 32'(out_valid), 32'd1);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            chk_res("bp", 8'h80, 1'b0, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        consume();
        chk("bp.rel_ready", 32'(in_ready), 32'd1);
        chk("bp.rel_valid", 32'(out_valid), 32'd0);

        // reset during the second RUN cycle
        a = 8'h11; b = 8'h22; sel = OP_ADD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst.valid", 32'(out_valid), 32'd0);
        chk("mid_rst.z", 32'(z), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst.no_result", 32'(out_valid), 32'd0);

        run_op(8'h5A, 8'h3C, 5'b00011, 1'b1, 1'b1, lat);
        chk("ill.lat", 32'(lat), 32'd4);
        chk_res("ill", 8'h00, 1'b0, 1'b0, 1'b1);
        consume();
        run_op(8'h5A, 8'h3C, 5'b00000, 1'b0, 1'b0, lat);
        chk_res("ill0", 8'h00, 1'b0, 1'b0, 1'b1);
        consume();
        run_op(8'h10, 8'h01, OP_SUB, 1'b0, 1'b0, lat);
        chk_res("err_clr", 8'h0F, 1'b0, 1'b0, 1'b0);
        consume();

        // 16-bit sweep across three slice widths
        for (int v = 0; v < 24; v++) begin
            logic [15:0] ez;
            logic        ec, eo, ee;
            int          wlat [3];
            logic [15:0] gz [3];
            logic [2:0]  gc, go, ge;
            wa   = 16'($urandom);
            wb   = (v == 0) ? wa : 16'($urandom);
            wsel = ops[$urandom_range(0, 6)];
            if (v == 0) wsel = OP_XOR;
            wcin = 1'($urandom);
            wbin = 1'($urandom);
            ref16(wa, wb, wsel, wcin, wbin, ez, ec, eo, ee);
            chk("sw.in_ready", 32'(wrdy), 32'h7);
            wvalid = 1'b1;
            @(posedge clk); #1;
            wvalid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                wlat[k] = 0; gz[k] = '0;
            end
            gc = '0; go = '0; ge = '0;
            for (int cyc = 1; cyc <= 20; cyc++) begin
                @(posedge clk); #1;
                for (int k = 0; k < 3; k++) begin
                    if (wval[k] && wlat[k] == 0) begin
                        wlat[k] = cyc; gz[k] = wz[k]; gc[k] = wc[k]; go[k] = wov[k]; ge[k] = werr[k];
                    end
                end
            end
            chk("sw.lat_s1", 32'(wlat[0]), 32'd16);
            chk("sw.lat_s4", 32'(wlat[1]), 32'd4);
            chk("sw.lat_s16", 32'(wlat[2]), 32'd1);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("sw%0d.z", k), 32'(gz[k]), 32'(ez));
                chk($sformatf("sw%0d.carry", k), 32'(gc[k]), 32'(ec));
                chk($sformatf("sw%0d.ovf", k), 32'(go[k]), 32'(eo));
                chk($sformatf("sw%0d.err", k), 32'(ge[k]), 32'(ee));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
